// File: rtl/gcd_sweep_driver_if.sv
// ============================================================================
// Module   : gcd_sweep_driver_if
// Purpose  : Start/Ack handshake and operand/result bus between the sweep
//            driver (master) and the GCD core (slave).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gcd_sweep_driver_if #(
    parameter int W = 8
);
    logic         Start;
    logic         Ack;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic         q_Sub;
    logic         q_Done;
    logic [W-1:0] AB_GCD;

    modport master (
        output Start, Ack, Ain, Bin,
        input  q_Sub, q_Done, AB_GCD
    );

    modport slave (
        input  Start, Ack, Ain, Bin,
        output q_Sub, q_Done, AB_GCD
    );
endinterface

`default_nettype wire

// File: rtl/gcd_sweep_driver.sv
// ============================================================================
// Module   : gcd_sweep_driver
// Purpose  : Sweeps every (Ain, Bin) operand pair through the GCD core and
//            reports per-pair result, computation clocks and sweep stats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_sweep_driver #(
    parameter int W       = 8,
    parameter int A_MIN   = 2,
    parameter int A_MAX   = 63,
    parameter int B_MIN   = 2,
    parameter int B_MAX   = 63,
    parameter int TIMEOUT = 1023
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    input  wire logic          CEN,
    input  wire logic          Go,
    gcd_sweep_driver_if.master core,
    output logic               Busy,
    output logic               Sweep_Done,
    output logic               Err,
    output logic               Pair_Valid,
    output logic [W-1:0]       Last_GCD,
    output logic [15:0]        Last_Clocks,
    output logic [15:0]        Max_Clocks,
    output logic [15:0]        Pair_Count
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_START, S_WAIT_SUB, S_WAIT_DONE,
        S_ACK, S_GAP, S_NEXT, S_FINISH, S_ERR
    } state_t;

    localparam logic [W-1:0] c_a_min = W'(A_MIN);
    localparam logic [W-1:0] c_a_max = W'(A_MAX);
    localparam logic [W-1:0] c_b_min = W'(B_MIN);
    localparam logic [W-1:0] c_b_max = W'(B_MAX);

    state_t       state_q, state_d;
    logic [W-1:0] ain_q, ain_d, bin_q, bin_d;
    logic         start_q, start_d, ack_q, ack_d;
    logic         busy_q, busy_d, done_q, done_d, err_q, err_d, pv_q, pv_d;
    logic [W-1:0] last_gcd_q, last_gcd_d;
    logic [15:0]  last_clk_q, last_clk_d, max_clk_q, max_clk_d;
    logic [15:0]  pair_cnt_q, pair_cnt_d, cnt_q, cnt_d;
    logic [15:0]  cnt_inc, pair_inc;

    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign pair_inc = (pair_cnt_q == 16'hFFFF) ? pair_cnt_q : pair_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        ain_d      = ain_q;
        bin_d      = bin_q;
        start_d    = 1'b0;
        ack_d      = 1'b0;
        pv_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        last_gcd_d = last_gcd_q;
        last_clk_d = last_clk_q;
        max_clk_d  = max_clk_q;
        pair_cnt_d = pair_cnt_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE, S_FINISH, S_ERR: begin
                if (Go) begin
                    state_d    = S_SETUP;
                    pair_cnt_d = 16'd0;
                    max_clk_d  = 16'd0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                    ain_d      = c_a_min;
                    bin_d      = c_b_min;
                    busy_d     = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_START;
                start_d = 1'b1;
            end
            S_START: state_d = S_WAIT_SUB;
            // q_Sub wins even if q_Done is already high, so the count restarts at 0.
            S_WAIT_SUB: begin
                if (core.q_Sub) begin
                    cnt_d   = 16'd0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (core.q_Done) begin
                    last_gcd_d = core.AB_GCD;
                    last_clk_d = cnt_q;
                    if (cnt_q > max_clk_q) max_clk_d = cnt_q;
                    pair_cnt_d = pair_inc;
                    pv_d       = 1'b1;
                    ack_d      = 1'b1;
                    state_d    = S_ACK;
                end else if ({16'd0, cnt_inc} >= 32'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ACK: state_d = S_GAP;
            S_GAP: begin
                if (!core.q_Done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (bin_q < c_b_max) begin
                    bin_d   = bin_q + 1'b1;
                    state_d = S_SETUP;
                end else if (ain_q < c_a_max) begin
                    bin_d   = c_b_min;
                    ain_d   = ain_q + 1'b1;
                    state_d = S_SETUP;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ain_q      <= c_a_min;
            bin_q      <= c_b_min;
            start_q    <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pv_q       <= 1'b0;
            last_gcd_q <= '0;
            last_clk_q <= 16'd0;
            max_clk_q  <= 16'd0;
            pair_cnt_q <= 16'd0;
            cnt_q      <= 16'd0;
        end else if (CEN) begin
            state_q    <= state_d;
            ain_q      <= ain_d;
            bin_q      <= bin_d;
            start_q    <= start_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pv_q       <= pv_d;
            last_gcd_q <= last_gcd_d;
            last_clk_q <= last_clk_d;
            max_clk_q  <= max_clk_d;
            pair_cnt_q <= pair_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign core.Start  = start_q;
    assign core.Ack    = ack_q;
    assign core.Ain    = ain_q;
    assign core.Bin    = bin_q;
    assign Busy        = busy_q;
    assign Sweep_Done  = done_q;
    assign Err         = err_q;
    assign Pair_Valid  = pv_q;
    assign Last_GCD    = last_gcd_q;
    assign Last_Clocks = last_clk_q;
    assign Max_Clocks  = max_clk_q;
    assign Pair_Count  = pair_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_sweep_driver.sv
// ============================================================================
// Module   : tb_gcd_sweep_driver
// Purpose  : Directed bench for gcd_sweep_driver: a small 2..3 sweep with a
//            subtract-loop core model, plus a full default sweep alongside.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gcd_sweep_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, rst_f, cen_s, go_s, go_f, cen_toggle;
    logic never_done;
    int   n_checks = 0;
    int   n_err    = 0;

    // small DUT: 2..3 x 2..3, TIMEOUT 15
    gcd_sweep_driver_if #(.W(8)) bus_s ();
    logic        busy_s, sd_s, err_s, pv_s;
    logic [7:0]  lg_s;
    logic [15:0] lc_s, mc_s, pc_s;

    gcd_sweep_driver #(.W(8), .A_MIN(2), .A_MAX(3), .B_MIN(2), .B_MAX(3), .TIMEOUT(15)) dut_s (
        .Clk(clk), .Reset(rst_s), .CEN(cen_s), .Go(go_s), .core(bus_s),
        .Busy(busy_s), .Sweep_Done(sd_s), .Err(err_s), .Pair_Valid(pv_s),
        .Last_GCD(lg_s), .Last_Clocks(lc_s), .Max_Clocks(mc_s), .Pair_Count(pc_s)
    );

    // full default sweep DUT
    gcd_sweep_driver_if #(.W(8)) bus_f ();
    logic        busy_f, sd_f, err_f, pv_f;
    logic [7:0]  lg_f;
    logic [15:0] lc_f, mc_f, pc_f;
    logic        cen_f = 1'b1;

    gcd_sweep_driver dut_f (
        .Clk(clk), .Reset(rst_f), .CEN(cen_f), .Go(go_f), .core(bus_f),
        .Busy(busy_f), .Sweep_Done(sd_f), .Err(err_f), .Pair_Valid(pv_f),
        .Last_GCD(lg_f), .Last_Clocks(lc_f), .Max_Clocks(mc_f), .Pair_Count(pc_f)
    );

    // core models: q_I=0, q_Sub=1, q_Done=2; one subtraction per enabled clock
    logic [1:0] cs_st, cf_st;
    logic [7:0] cs_a, cs_b, cf_a, cf_b;

    always @(posedge clk) begin
        if (rst_s) cs_st <= 2'd0;
        else if (cen_s) begin
            case (cs_st)
                2'd0: if (bus_s.Start) begin cs_a <= bus_s.Ain; cs_b <= bus_s.Bin; cs_st <= 2'd1; end
                2'd1: if (cs_a == cs_b) begin if (!never_done) cs_st <= 2'd2; end
                      else if (cs_a > cs_b) cs_a <= cs_a - cs_b;
                      else cs_b <= cs_b - cs_a;
                default: if (bus_s.Ack) cs_st <= 2'd0;
            endcase
        end
    end
    assign bus_s.q_Sub  = (cs_st == 2'd1);
    assign bus_s.q_Done = (cs_st == 2'd2);
    assign bus_s.AB_GCD = cs_a;

    always @(posedge clk) begin
        if (rst_f) cf_st <= 2'd0;
        else begin
            case (cf_st)
                2'd0: if (bus_f.Start) begin cf_a <= bus_f.Ain; cf_b <= bus_f.Bin; cf_st <= 2'd1; end
                2'd1: if (cf_a == cf_b) cf_st <= 2'd2;
                      else if (cf_a > cf_b) cf_a <= cf_a - cf_b;
                      else cf_b <= cf_b - cf_a;
                default: if (bus_f.Ack) cf_st <= 2'd0;
            endcase
        end
    end
    assign bus_f.q_Sub  = (cf_st == 2'd1);
    assign bus_f.q_Done = (cf_st == 2'd2);
    assign bus_f.AB_GCD = cf_a;

    int n_start = 0;
    int n_ack   = 0;
    always @(posedge clk) begin
        if (!rst_s && cen_s && bus_s.Start) n_start++;
        if (!rst_s && cen_s && bus_s.Ack)   n_ack++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    int exp_fa = 2;
    int exp_fb = 2;
    int f_max  = 0;
    always @(negedge clk) begin
        if (pv_f) begin
            check("full_pair", {bus_f.Ain, bus_f.Bin}, {exp_fa[7:0], exp_fb[7:0]});
            check("full_gcd", lg_f, gcd_ref(exp_fa, exp_fb));
            if (int'(lc_f) > f_max) f_max = int'(lc_f);
            if (exp_fb < 63) exp_fb++;
            else begin exp_fb = 2; exp_fa++; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (cen_toggle) cen_s = ~cen_s;
    endtask

    task automatic wait_pv(input string tag);
        int n = 0;
        while (pv_s && n < 400) begin tick(); n++; end
        while (!pv_s && n < 400) begin tick(); n++; end
        check({tag, "_pv_seen"}, pv_s, 1);
    endtask

    task automatic wait_sd(input string tag);
        int n = 0;
        while (!sd_s && n < 600) begin tick(); n++; end
        check({tag, "_sweep_done"}, sd_s, 1);
    endtask

    logic [7:0]  exp_gcd [4] = '{8'd2, 8'd1, 8'd1, 8'd3};
    logic [15:0] exp_clk [4] = '{16'd0, 16'd2, 16'd2, 16'd0};
    logic [15:0] exp_ab  [4] = '{16'h0202, 16'h0203, 16'h0302, 16'h0303};

    task automatic run_small(input string tag);
        for (int i = 0; i < 4; i++) begin
            wait_pv(tag);
            check({tag, "_pair"}, {bus_s.Ain, bus_s.Bin}, exp_ab[i]);
            check({tag, "_gcd"}, lg_s, exp_gcd[i]);
            check({tag, "_clocks"}, lc_s, exp_clk[i]);
            check({tag, "_count"}, pc_s, i + 1);
        end
        wait_sd(tag);
        check({tag, "_busy_end"}, busy_s, 0);
        check({tag, "_count_end"}, pc_s, 4);
        check({tag, "_max"}, mc_s, 2);
    endtask

    initial begin
        int n, s0, a0;
        rst_s = 1'b1; rst_f = 1'b1; cen_s = 1'b1; go_s = 1'b0; go_f = 1'b0;
        cen_toggle = 1'b0; never_done = 1'b0;
        tick(); tick();
        rst_s = 1'b0; rst_f = 1'b0;
        check("rst_ain_bin", {bus_s.Ain, bus_s.Bin}, 16'h0202);
        check("rst_flags", {busy_s, sd_s, err_s, pv_s, bus_s.Start, bus_s.Ack}, 0);
        check("rst_regs", {lg_s, lc_s, mc_s, pc_s}, 0);

        go_f = 1'b1; tick(); go_f = 1'b0;

        // basic sweep, CEN held high
        s0 = n_start; a0 = n_ack;
        go_s = 1'b1; tick(); go_s = 1'b0;
        tick();
        check("t1_busy", busy_s, 1);
        run_small("t1");
        check("t1_starts", n_start - s0, 4);
        check("t1_acks", n_ack - a0, 4);

        // same sweep with CEN toggling every clock
        s0 = n_start; a0 = n_ack;
        go_s = 1'b1; cen_toggle = 1'b1; tick(); go_s = 1'b0;
        run_small("t2");
        check("t2_starts", n_start - s0, 4);
        check("t2_acks", n_ack - a0, 4);
        cen_toggle = 1'b0; cen_s = 1'b1;

        // reset while pair (2,3) is in WAIT_DONE, with CEN low
        go_s = 1'b1; tick(); go_s = 1'b0;
        wait_pv("t3_first");
        n = 0;
        while (!(bus_s.q_Sub && bus_s.Bin == 8'd3) && n < 100) begin tick(); n++; end
        check("t3_reach_23", {bus_s.q_Sub, bus_s.Bin}, {1'b1, 8'd3});
        tick();
        rst_s = 1'b1; cen_s = 1'b0; tick(); rst_s = 1'b0;
        check("t3_rst_ain_bin", {bus_s.Ain, bus_s.Bin}, 16'h0202);
        check("t3_rst_flags", {busy_s, sd_s, err_s, pv_s, bus_s.Start, bus_s.Ack}, 0);
        check("t3_rst_regs", {lg_s, lc_s, mc_s, pc_s}, 0);
        cen_s = 1'b1;

        // restart, then pulse Go during WAIT_SUB of the second pair
        go_s = 1'b1; tick(); go_s = 1'b0;
        wait_pv("t3_restart");
        check("t3_restart_pair", {bus_s.Ain, bus_s.Bin, lg_s}, {16'h0202, 8'd2});
        check("t3_restart_count", pc_s, 1);
        n = 0;
        while (!bus_s.Start && n < 100) begin tick(); n++; end
        check("t5_start_seen", bus_s.Start, 1);
        tick();
        go_s = 1'b1; tick(); go_s = 1'b0;
        wait_pv("t5_after_go");
        check("t5_pair", {bus_s.Ain, bus_s.Bin, lg_s}, {16'h0203, 8'd1});
        check("t5_count", pc_s, 2);
        wait_sd("t5");
        check("t5_count_end", pc_s, 4);

        // core never finishes: timeout after 15 WAIT_DONE clocks
        never_done = 1'b1;
        go_s = 1'b1; tick(); go_s = 1'b0;
        n = 0;
        while (!bus_s.q_Sub && n < 100) begin tick(); n++; end
        check("t4_sub_seen", bus_s.q_Sub, 1);
        n = 0;
        while (!err_s && n < 40) begin tick(); n++; end
        check("t4_err_delay", n, 16);
        check("t4_flags", {err_s, busy_s, sd_s, bus_s.Start, bus_s.Ack}, 5'b10000);
        check("t4_count", pc_s, 0);

        // full default sweep, running alongside since the start
        n = 0;
        while (!sd_f && n < 95000) begin tick(); n++; end
        check("full_done", sd_f, 1);
        check("full_count", pc_f, 3844);
        check("full_max", mc_f, f_max);
        check("full_flags", {busy_f, err_f}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
